// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined add/subtract built from GRP-bit
// carry-lookahead groups, one group resolved per pipeline stage.
module cla_pipe_addsub #(
    parameter int WIDTH = 16,
    parameter int GRP   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSTG = WIDTH / GRP;

    if ((WIDTH % GRP) != 0) begin : g_bad_param
        $error("cla_pipe_addsub: WIDTH must be a multiple of GRP");
    end

    // Returns {carry into group MSB, group carry out, group sum}.
    function automatic logic [GRP+1:0] f_cla(
        input logic [GRP-1:0] fa,
        input logic [GRP-1:0] fb,
        input logic           fc
    );
        logic [GRP-1:0] p;
        logic [GRP-1:0] g;
        logic [GRP:0]   c;
        logic           t;
        logic           term;
        p    = fa ^ fb;
        g    = fa & fb;
        c    = '0;
        c[0] = fc;
        for (int i = 1; i <= GRP; i++) begin
            t = fc;
            for (int j = 0; j < i; j++) t = t & p[j];
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                t = t | term;
            end
            c[i] = t;
        end
        return {c[GRP-1], c[GRP], p ^ c[GRP-1:0]};
    endfunction

    logic [NSTG-1:0]  r_v;
    logic [NSTG-1:0]  r_c;
    logic [WIDTH-1:0] r_a [NSTG];
    logic [WIDTH-1:0] r_b [NSTG];
    logic [WIDTH-1:0] r_s [NSTG];
    logic             r_ov;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic [GRP+1:0]   w_res [NSTG];
    logic [WIDTH-1:0] w_sn  [NSTG];
    logic             w_en;
    logic [GRP+1:0]   w_last;

    assign w_en     = out_ready | ~r_ov;
    assign in_ready = w_en;
    assign w_last   = w_res[NSTG-1];

    // Each stage resolves its own group and merges it into the de-skewed sum.
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            w_res[k] = f_cla(r_a[k][k*GRP +: GRP], r_b[k][k*GRP +: GRP], r_c[k]);
            w_sn[k]  = r_s[k];
            w_sn[k][k*GRP +: GRP] = w_res[k][GRP-1:0];
        end
    end

    // Whole pipe advances in lockstep when the output slot can move.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_c    <= '0;
            r_ov   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_en) begin
            r_v[0] <= in_valid;
            r_a[0] <= a;
            r_b[0] <= sub ? ~b : b;
            r_c[0] <= cin ^ sub;
            r_s[0] <= '0;
            for (int k = 1; k < NSTG; k++) begin
                r_v[k] <= r_v[k-1];
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
                r_c[k] <= w_res[k-1][GRP];
                r_s[k] <= w_sn[k-1];
            end
            r_ov   <= r_v[NSTG-1];
            r_sum  <= w_sn[NSTG-1];
            r_cout <= w_last[GRP];
            r_ovf  <= w_last[GRP+1] ^ w_last[GRP];
            r_zero <= ~|w_sn[NSTG-1];
        end
    end

    assign out_valid = r_ov;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
endmodule
